// File: rtl/clk_div_ctrl_if.sv
// Control and status bundle between a controller and clk_div_ctrl.
// Latency: none, plain wires; no backpressure.
interface clk_div_ctrl_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic [1:0]           mode;
  logic                 step_req;
  logic [WIDTH-1:0]     div_value;
  logic                 div_load;
  logic                 clk_sys;
  logic                 tick;
  logic                 running;
  logic                 div_pending;
  logic [CNT_WIDTH-1:0] tick_count;

  modport master (
    output mode, step_req, div_value, div_load,
    input  clk_sys, tick, running, div_pending, tick_count
  );

  modport slave (
    input  mode, step_req, div_value, div_load,
    output clk_sys, tick, running, div_pending, tick_count
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run/halt/single-step slow-clock divider; CLK_DIV_TICK_COUNT_EN builds the tick counter.
// Latency: clk_sys rises 1 cycle after RUN from halt; no backpressure, mode acts only at half boundaries.
module clk_div_ctrl #(
  parameter int WIDTH     = 32,
  parameter int RESET_DIV = 100000,
  parameter int CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  clk_div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_RUN  = 2'b01;
  localparam logic [1:0]       MODE_STEP = 2'b10;
  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DIV);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] counter, counter_nxt;
  logic [WIDTH-1:0] div_active, shadow, half_last;
  logic             clk_sys_q, clk_sys_nxt;
  logic             tick_q, tick_nxt;
  logic             pending_q, step_q;
  logic             step_edge, boundary, rise, run_req, apply;

  // A zero divisor behaves as one: the half boundary is every cycle.
  assign half_last = (div_active == '0) ? '0 : div_active - WIDTH'(1);
  assign boundary  = (counter == half_last);
  assign run_req   = (bus.mode == MODE_RUN);
  assign step_edge = bus.step_req & ~step_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_HALT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HALT: begin
        if (run_req)
          state_nxt = S_RUN;
        else if ((bus.mode == MODE_STEP) && step_edge)
          state_nxt = S_STEP;
      end
      S_RUN:   if (boundary && !run_req)    state_nxt = S_HALT;
      S_STEP:  if (boundary && !clk_sys_q)  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    clk_sys_nxt = clk_sys_q;
    tick_nxt    = 1'b0;
    counter_nxt = counter + WIDTH'(1);
    rise        = 1'b0;
    case (state)
      S_HALT: begin
        clk_sys_nxt = 1'b0;
        counter_nxt = '0;
        if (state_nxt != S_HALT) begin
          clk_sys_nxt = 1'b1;
          tick_nxt    = 1'b1;
        end
      end
      S_RUN, S_STEP: begin
        if (boundary) begin
          counter_nxt = '0;
          if (clk_sys_q) begin
            clk_sys_nxt = 1'b0;
          end else if ((state == S_RUN) && run_req) begin
            clk_sys_nxt = 1'b1;
            tick_nxt    = 1'b1;
            rise        = 1'b1;
          end
        end
      end
      default: begin
        clk_sys_nxt = 1'b0;
        counter_nxt = '0;
      end
    endcase
  end

  // New divisor lands only at a period start so both halves always match.
  assign apply = pending_q & ((state == S_HALT) | rise);

  always_ff @(posedge clk) begin
    if (reset) begin
      counter    <= '0;
      clk_sys_q  <= 1'b0;
      tick_q     <= 1'b0;
      div_active <= RESET_VAL;
      shadow     <= RESET_VAL;
      pending_q  <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      counter   <= counter_nxt;
      clk_sys_q <= clk_sys_nxt;
      tick_q    <= tick_nxt;
      step_q    <= bus.step_req;
      if (apply) begin
        div_active <= shadow;
        pending_q  <= 1'b0;
      end
      if (bus.div_load) begin
        shadow    <= bus.div_value;
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.clk_sys     = clk_sys_q;
  assign bus.tick        = tick_q;
  assign bus.running     = (state != S_HALT);
  assign bus.div_pending = pending_q;

`ifdef CLK_DIV_TICK_COUNT_EN
  logic [CNT_WIDTH-1:0] tick_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)       tick_cnt_q <= '0;
    else if (tick_q) tick_cnt_q <= tick_cnt_q + CNT_WIDTH'(1);
  end

  assign bus.tick_count = tick_cnt_q;
`else
  assign bus.tick_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with RESET_DIV=4, CNT_WIDTH=4.
module tb_clk_div_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef CLK_DIV_TICK_COUNT_EN
  localparam logic [3:0] TC_EXP = 4'd1;
`else
  localparam logic [3:0] TC_EXP = 4'd0;
`endif

  always #5 clk = ~clk;

  clk_div_ctrl_if #(.WIDTH(32), .CNT_WIDTH(4)) bus ();

  clk_div_ctrl #(.WIDTH(32), .RESET_DIV(4), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.mode      = 2'b00;
    bus.step_req  = 1'b0;
    bus.div_value = '0;
    bus.div_load  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_sys", bus.clk_sys, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_pending", bus.div_pending, 0);
    chk("rst_tick_count", bus.tick_count, 0);

    // Free run, H=4: 4 high / 4 low, tick at each rise
    reset    = 1'b0;
    bus.mode = 2'b01;
    for (int s = 1; s <= 16; s++) begin
      @(negedge clk);
      chk("run_clk", bus.clk_sys, ((s - 1) % 8) < 4);
      chk("run_tick", bus.tick, ((s - 1) % 8) == 0);
      chk("run_running", bus.running, 1);
    end

    // HALT requested one cycle into a high phase
    @(negedge clk);
    chk("halt_rise_clk", bus.clk_sys, 1);
    chk("halt_rise_tick", bus.tick, 1);
    bus.mode = 2'b00;
    for (int s = 18; s <= 20; s++) begin
      @(negedge clk);
      chk("halt_high_clk", bus.clk_sys, 1);
      chk("halt_high_running", bus.running, 1);
      chk("halt_high_tick", bus.tick, 0);
    end
    for (int s = 21; s <= 25; s++) begin
      @(negedge clk);
      chk("halted_clk", bus.clk_sys, 0);
      chk("halted_running", bus.running, 0);
      chk("halted_tick", bus.tick, 0);
    end

    // Single step, button held 20 cycles with a re-press mid-period
    bus.mode     = 2'b10;
    bus.step_req = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      chk("step_clk", bus.clk_sys, s <= 4);
      chk("step_tick", bus.tick, s == 1);
      chk("step_running", bus.running, s <= 8);
      if (s == 3) bus.step_req = 1'b0;
      if (s == 4) bus.step_req = 1'b1;
    end
    bus.step_req = 1'b0;
    bus.mode     = 2'b00;
    @(negedge clk);

    // Divisor 2 loaded mid high phase: applied at next rise
    bus.mode = 2'b01;
    for (int s = 1; s <= 16; s++) begin
      @(negedge clk);
      if (s <= 4)      chk("load_clk", bus.clk_sys, 1);
      else if (s <= 8) chk("load_clk", bus.clk_sys, 0);
      else             chk("load_clk", bus.clk_sys, ((s - 9) % 4) < 2);
      chk("load_tick", bus.tick, (s == 1) || (s == 9) || (s == 13));
      chk("load_pending", bus.div_pending, (s >= 3) && (s <= 8));
      if (s == 2) begin
        bus.div_value = 32'd2;
        bus.div_load  = 1'b1;
      end
      if (s == 3) bus.div_load = 1'b0;
    end

    // Divisor 0 loaded in HALT behaves as 1
    bus.mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("zero_halt_clk", bus.clk_sys, 0);
    chk("zero_halt_running", bus.running, 0);
    bus.div_value = 32'd0;
    bus.div_load  = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    chk("zero_pending_set", bus.div_pending, 1);
    @(negedge clk);
    chk("zero_pending_clr", bus.div_pending, 0);
    bus.mode = 2'b01;
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      chk("zero_clk", bus.clk_sys, s % 2);
      chk("zero_tick", bus.tick, s % 2);
    end

    // Reset mid-high phase with a divisor pending
    bus.div_value = 32'd7;
    bus.div_load  = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    chk("pre_rst_clk", bus.clk_sys, 1);
    chk("pre_rst_pending", bus.div_pending, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_clk_sys", bus.clk_sys, 0);
    chk("mid_rst_tick", bus.tick, 0);
    chk("mid_rst_running", bus.running, 0);
    chk("mid_rst_pending", bus.div_pending, 0);
    chk("mid_rst_tick_count", bus.tick_count, 0);

    // RESET_DIV restored; 17 ticks wrap a 4-bit count to 1
    reset = 1'b0;
    for (int s = 1; s <= 130; s++) begin
      @(negedge clk);
      if (s == 1)   chk("rerun_first_rise", bus.clk_sys, 1);
      if (s == 4)   chk("rerun_high_end", bus.clk_sys, 1);
      if (s == 5)   chk("rerun_low_start", bus.clk_sys, 0);
      if (s == 129) chk("cnt_tick17", bus.tick, 1);
      if (s == 130) chk("cnt_wrap", bus.tick_count, TC_EXP);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
